// File: rtl/cpu_fetch_pkg.sv
// Shared CPU definitions used by the fetch stage and predecode logic:
// RV32 control-flow opcodes and the fetch state encoding.
package cpu_fetch_pkg;

  localparam int OPCODE_WIDTH = 7;

  localparam logic [OPCODE_WIDTH-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPCODE_WIDTH-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPCODE_WIDTH-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_WIDTH-1:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [0:0] {
    FETCH     = 1'b0,
    WAIT_JUMP = 1'b1
  } fetchState_e;

endpackage

// File: rtl/cpu_fetch_predecode.sv
// Combinational predecode: flags instructions whose successor PC is only
// known after execute (jumps, branches, system instructions).
module cpu_fetch_predecode
  import cpu_fetch_pkg::*;
#(
  parameter int OPCODE_W = OPCODE_WIDTH
) (
  input  logic [31:0] i_word,
  output logic        o_is_jump
);

  logic [OPCODE_W-1:0] opcode;

  assign opcode = i_word[OPCODE_W-1:0];

  always_comb begin
    o_is_jump = 1'b0;
    if ((opcode == OPCODE_W'(OP_JAL))    ||
        (opcode == OPCODE_W'(OP_JALR))   ||
        (opcode == OPCODE_W'(OP_BRANCH)) ||
        (opcode == OPCODE_W'(OP_SYSTEM))) begin
      o_is_jump = 1'b1;
    end
  end

endmodule

// File: rtl/cpu_fetch.sv
// Instruction fetch stage: owns the fetch PC, feeds decode through a
// one-entry output register, and halts on control flow until execute resolves it.
module cpu_fetch
  import cpu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          OPCODE_W     = 7
) (
  input  logic        i_clock,
  input  logic        i_reset,
  output logic [31:0] o_icache_pc,
  output logic        o_icache_stall,
  input  logic        i_icache_ready,
  input  logic [31:0] i_icache_rdata,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_instruction,
  output logic [31:0] o_pc,
  output logic        o_is_jump,
  input  logic        i_jump,
  input  logic [31:0] i_jump_pc,
  output logic [31:0] o_fetch_count
);

  fetchState_e state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instrPc_q, instrPc_d;
  logic        isJump_q, isJump_d;
  logic [31:0] fetchCount_q, fetchCount_d;

  logic        outFree;
  logic        fetchFire;
  logic        predIsJump;
  logic [31:0] jumpTarget;

  cpu_fetch_predecode #(
    .OPCODE_W (OPCODE_W)
  ) u_predecode (
    .i_word    (i_icache_rdata),
    .o_is_jump (predIsJump)
  );

  assign outFree    = !valid_q || i_ready;
  assign fetchFire  = (state_q == FETCH) && i_icache_ready && outFree;
  assign jumpTarget = i_jump_pc & 32'hFFFF_FFFC;

  // A word returned while the output register is full is dropped; the cache
  // was told to stall, so this only happens on a protocol violation.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    valid_d      = valid_q;
    instr_d      = instr_q;
    instrPc_d    = instrPc_q;
    isJump_d     = isJump_q;
    fetchCount_d = fetchCount_q;

    if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      FETCH: begin
        if (fetchFire) begin
          valid_d      = 1'b1;
          instr_d      = i_icache_rdata;
          instrPc_d    = pc_q;
          isJump_d     = predIsJump;
          fetchCount_d = fetchCount_q + 32'd1;
          if (predIsJump) begin
            state_d = WAIT_JUMP;
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end
      end
      WAIT_JUMP: begin
        if (i_jump) begin
          pc_d    = jumpTarget;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_VECTOR;
      valid_q      <= 1'b0;
      instr_q      <= 32'h0;
      instrPc_q    <= 32'h0;
      isJump_q     <= 1'b0;
      fetchCount_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      instrPc_q    <= instrPc_d;
      isJump_q     <= isJump_d;
      fetchCount_q <= fetchCount_d;
    end
  end

  assign o_icache_pc    = pc_q;
  assign o_icache_stall = (state_q != FETCH) || !outFree;
  assign o_valid        = valid_q;
  assign o_instruction  = instr_q;
  assign o_pc           = instrPc_q;
  assign o_is_jump      = isJump_q;
  assign o_fetch_count  = fetchCount_q;

endmodule

// File: tb/tb_cpu_fetch.sv
// Directed testbench for cpu_fetch: sequential fetch, backpressure, jump
// resolution, PC wrap, async reset mid-wait and predecode coverage.
module tb_cpu_fetch;

  localparam logic [31:0] RV        = 32'h0000_1000;
  localparam logic [31:0] W_ADDI1   = 32'h0010_0093;
  localparam logic [31:0] W_ADDI2   = 32'h0020_0113;
  localparam logic [31:0] W_JAL     = 32'h0080_006F;
  localparam logic [31:0] W_JALR    = 32'h0000_8067;
  localparam logic [31:0] W_BRANCH  = 32'h0000_0063;
  localparam logic [31:0] W_SYSTEM  = 32'h0000_0073;
  localparam logic [31:0] W_LUI     = 32'h0000_10B7;
  localparam logic [31:0] W_RSVD    = 32'h0000_006B;

  logic        i_clock;
  logic        i_reset;
  logic [31:0] o_icache_pc;
  logic        o_icache_stall;
  logic        i_icache_ready;
  logic [31:0] i_icache_rdata;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_instruction;
  logic [31:0] o_pc;
  logic        o_is_jump;
  logic        i_jump;
  logic [31:0] i_jump_pc;
  logic [31:0] o_fetch_count;

  int testsRun    = 0;
  int testsFailed = 0;

  cpu_fetch #(
    .RESET_VECTOR (RV),
    .OPCODE_W     (7)
  ) dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .o_icache_pc    (o_icache_pc),
    .o_icache_stall (o_icache_stall),
    .i_icache_ready (i_icache_ready),
    .i_icache_rdata (i_icache_rdata),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_instruction  (o_instruction),
    .o_pc           (o_pc),
    .o_is_jump      (o_is_jump),
    .i_jump         (i_jump),
    .i_jump_pc      (i_jump_pc),
    .o_fetch_count  (o_fetch_count)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic tick;
    @(posedge i_clock);
    #1;
  endtask

  task automatic applyReset;
    i_reset        = 1'b0;
    i_icache_ready = 1'b0;
    i_icache_rdata = 32'h0;
    i_ready        = 1'b0;
    i_jump         = 1'b0;
    i_jump_pc      = 32'h0;
    tick();
    tick();
    i_reset = 1'b1;
    tick();
  endtask

  // One cache-ready pulse carrying word w.
  task automatic fetchWord(input logic [31:0] w);
    i_icache_rdata = w;
    i_icache_ready = 1'b1;
    tick();
    i_icache_ready = 1'b0;
    i_icache_rdata = 32'h0;
  endtask

  task automatic test_reset;
    applyReset();
    testsRun++;
    if (o_valid !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL reset_valid: got %b expected 0", o_valid);
    end
    testsRun++;
    if (o_icache_pc !== RV) begin
      testsFailed++; $display("[TB] FAIL reset_pc: got %h expected %h", o_icache_pc, RV);
    end
    testsRun++;
    if (o_fetch_count !== 32'd0 || o_is_jump !== 1'b0 || o_pc !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_regs: got count=%0d jump=%b pc=%h expected 0/0/0", o_fetch_count, o_is_jump, o_pc);
    end
    testsRun++;
    if (o_icache_stall !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL reset_stall: got %b expected 0", o_icache_stall);
    end
  endtask

  task automatic test_sequential;
    applyReset();
    i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      testsRun++;
      if (o_icache_stall !== 1'b0) begin
        testsFailed++; $display("[TB] FAIL seq_stall%0d: got %b expected 0", k, o_icache_stall);
      end
      fetchWord(W_ADDI1);
      testsRun++;
      if (o_valid !== 1'b1 || o_pc !== RV + 32'(4 * k)) begin
        testsFailed++;
        $display("[TB] FAIL seq_out%0d: got valid=%b pc=%h expected 1/%h", k, o_valid, o_pc, RV + 32'(4 * k));
      end
    end
    testsRun++;
    if (o_fetch_count !== 32'd3) begin
      testsFailed++; $display("[TB] FAIL seq_count: got %0d expected 3", o_fetch_count);
    end
    testsRun++;
    if (o_icache_pc !== 32'h0000_100C) begin
      testsFailed++; $display("[TB] FAIL seq_pc: got %h expected 0000100c", o_icache_pc);
    end
  endtask

  task automatic test_backpressure;
    applyReset();
    i_ready = 1'b1;
    fetchWord(W_ADDI1);
    i_ready = 1'b0;
    tick();
    tick();
    testsRun++;
    if (o_icache_stall !== 1'b1 || o_valid !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL bp_stall: got stall=%b valid=%b expected 1/1", o_icache_stall, o_valid);
    end
    testsRun++;
    if (o_icache_pc !== 32'h0000_1004 || o_pc !== 32'h0000_1000) begin
      testsFailed++;
      $display("[TB] FAIL bp_hold: got cpc=%h opc=%h expected 00001004/00001000", o_icache_pc, o_pc);
    end
    i_ready = 1'b1;
    #1;
    testsRun++;
    if (o_icache_stall !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL bp_release: got %b expected 0", o_icache_stall);
    end
    fetchWord(W_ADDI2);
    testsRun++;
    if (o_valid !== 1'b1 || o_pc !== 32'h0000_1004 || o_instruction !== W_ADDI2) begin
      testsFailed++;
      $display("[TB] FAIL bp_reload: got valid=%b pc=%h instr=%h expected 1/00001004/%h", o_valid, o_pc, o_instruction, W_ADDI2);
    end
  endtask

  // Continues from test_backpressure: fetch PC is 1008, decode ready.
  task automatic test_jump;
    fetchWord(W_JAL);
    i_ready = 1'b0;
    #1;
    testsRun++;
    if (o_is_jump !== 1'b1 || o_pc !== 32'h0000_1008 || o_icache_stall !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL jal_out: got jump=%b pc=%h stall=%b expected 1/00001008/1", o_is_jump, o_pc, o_icache_stall);
    end
    tick();
    testsRun++;
    if (o_icache_pc !== 32'h0000_1008) begin
      testsFailed++; $display("[TB] FAIL jal_hold: got %h expected 00001008", o_icache_pc);
    end
    i_jump    = 1'b1;
    i_jump_pc = 32'h0000_2003;
    i_ready   = 1'b1;
    tick();
    i_jump = 1'b0;
    testsRun++;
    if (o_icache_pc !== 32'h0000_2000 || o_valid !== 1'b0 || o_icache_stall !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL jal_resolve: got cpc=%h valid=%b stall=%b expected 00002000/0/0", o_icache_pc, o_valid, o_icache_stall);
    end
    fetchWord(W_ADDI1);
    testsRun++;
    if (o_pc !== 32'h0000_2000 || o_is_jump !== 1'b0 || o_fetch_count !== 32'd4) begin
      testsFailed++;
      $display("[TB] FAIL jal_target: got pc=%h jump=%b count=%0d expected 00002000/0/4", o_pc, o_is_jump, o_fetch_count);
    end
  endtask

  task automatic test_wrap;
    fetchWord(W_BRANCH);
    testsRun++;
    if (o_is_jump !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL br_detect: got %b expected 1", o_is_jump);
    end
    i_jump    = 1'b1;
    i_jump_pc = 32'hFFFF_FFFF;
    tick();
    i_jump = 1'b0;
    testsRun++;
    if (o_icache_pc !== 32'hFFFF_FFFC) begin
      testsFailed++; $display("[TB] FAIL wrap_align: got %h expected fffffffc", o_icache_pc);
    end
    fetchWord(W_ADDI1);
    testsRun++;
    if (o_pc !== 32'hFFFF_FFFC || o_icache_pc !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL wrap_pc: got opc=%h cpc=%h expected fffffffc/00000000", o_pc, o_icache_pc);
    end
  endtask

  task automatic test_reset_mid_wait;
    applyReset();
    i_ready = 1'b1;
    fetchWord(W_JALR);
    i_ready = 1'b0;
    testsRun++;
    if (o_is_jump !== 1'b1 || o_valid !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL rst_pre: got jump=%b valid=%b expected 1/1", o_is_jump, o_valid);
    end
    #2;
    i_reset   = 1'b0;
    i_jump    = 1'b1;
    i_jump_pc = 32'h0000_3000;
    #1;
    testsRun++;
    if (o_valid !== 1'b0 || o_is_jump !== 1'b0 || o_instruction !== 32'h0 ||
        o_pc !== 32'h0 || o_fetch_count !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL rst_async: got valid=%b jump=%b instr=%h pc=%h count=%0d expected all 0",
               o_valid, o_is_jump, o_instruction, o_pc, o_fetch_count);
    end
    tick();
    i_jump  = 1'b0;
    i_reset = 1'b1;
    tick();
    testsRun++;
    if (o_icache_pc !== RV || o_icache_stall !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL rst_release: got cpc=%h stall=%b expected %h/0", o_icache_pc, o_icache_stall, RV);
    end
  endtask

  // Continues from test_reset_mid_wait: FETCH state at RESET_VECTOR.
  task automatic test_jump_in_fetch;
    i_ready   = 1'b1;
    i_jump    = 1'b1;
    i_jump_pc = 32'h0000_3000;
    tick();
    i_jump = 1'b0;
    testsRun++;
    if (o_icache_pc !== RV) begin
      testsFailed++; $display("[TB] FAIL fetchjump_idle: got %h expected %h", o_icache_pc, RV);
    end
    i_jump = 1'b1;
    fetchWord(W_ADDI1);
    i_jump = 1'b0;
    testsRun++;
    if (o_icache_pc !== 32'h0000_1004 || o_pc !== RV) begin
      testsFailed++;
      $display("[TB] FAIL fetchjump_load: got cpc=%h opc=%h expected 00001004/%h", o_icache_pc, o_pc, RV);
    end
  endtask

  task automatic test_predecode;
    fetchWord(W_SYSTEM);
    testsRun++;
    if (o_is_jump !== 1'b1 || o_icache_stall !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL pd_system: got jump=%b stall=%b expected 1/1", o_is_jump, o_icache_stall);
    end
    i_jump    = 1'b1;
    i_jump_pc = 32'h0000_4000;
    tick();
    i_jump = 1'b0;
    fetchWord(W_LUI);
    testsRun++;
    if (o_is_jump !== 1'b0 || o_pc !== 32'h0000_4000 || o_icache_pc !== 32'h0000_4004) begin
      testsFailed++;
      $display("[TB] FAIL pd_lui: got jump=%b opc=%h cpc=%h expected 0/00004000/00004004", o_is_jump, o_pc, o_icache_pc);
    end
    fetchWord(W_RSVD);
    testsRun++;
    if (o_is_jump !== 1'b0 || o_icache_pc !== 32'h0000_4008) begin
      testsFailed++;
      $display("[TB] FAIL pd_rsvd: got jump=%b cpc=%h expected 0/00004008", o_is_jump, o_icache_pc);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_jump();
    test_wrap();
    test_reset_mid_wait();
    test_jump_in_fetch();
    test_predecode();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/cpu_fetch.md
Name: cpu_fetch

Overview:
Instruction fetch stage, directly downstream of the instruction cache and upstream of decode.
- Owns the architectural fetch PC and presents it to the cache.
- Consumes each fetched word and hands it to decode through a one-entry output register with valid/ready handshake.
- Predecodes control-flow opcodes and halts fetch until execute supplies the resolved next PC.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC loaded at reset.
OPCODE_W, 7, width of RV32 opcode field used by predecode.

Ports:
i_clock  in  1  core clock, all state on rising edge.
i_reset  in  1  asynchronous, active-low reset; asserted low clears all state immediately.
o_icache_pc  out  32  fetch PC to cache; held stable until the word is accepted.
o_icache_stall  out  1  tells cache not to return/advance this cycle.
i_icache_ready  in  1  cache returns valid word this cycle (one-cycle pulse).
i_icache_rdata  in  32  instruction word, valid with i_icache_ready.
o_valid  out  1  output register holds an instruction for decode.
i_ready  in  1  decode accepts output register this cycle.
o_instruction  out  32  instruction word.
o_pc  out  32  PC of o_instruction.
o_is_jump  out  1  instruction is control-flow; fetch is waiting on i_jump.
i_jump  in  1  execute resolved a control-flow instruction.
i_jump_pc  in  32  resolved next PC, valid with i_jump.
o_fetch_count  out  32  retired-fetch counter (debug).

Behaviour:
- Reset (i_reset low, async): pc=RESET_VECTOR, state=FETCH, o_valid=0, o_instruction=0, o_pc=0, o_is_jump=0, o_fetch_count=0. Reset mid-wait discards the pending instruction and jump.
- o_icache_pc = pc at all times. pc only changes on an accepted fetch or an i_jump.
- Output register transfer: cleared when o_valid && i_ready, unless reloaded in the same cycle.
- Output register "free" = !o_valid || i_ready.
- Combinational: o_icache_stall = (state != FETCH) || !free.
- States:
  - FETCH:
    - If i_icache_ready && free: load o_instruction=i_icache_rdata, o_pc=pc, o_valid=1; increment o_fetch_count.
    - Predecode opcode = rdata[6:0]. Control-flow set: JAL 1101111, JALR 1100111, BRANCH 1100011, SYSTEM 1110011.
    - If control-flow: o_is_jump=1, state→WAIT_JUMP, pc unchanged. Otherwise pc = pc+4, mod 2^32 (32'hFFFF_FFFC+4 wraps to 0).
    - If i_icache_ready arrives while !free, it is a protocol violation: the cache must have seen stall. Bench asserts this never occurs; the word is not captured.
  - WAIT_JUMP:
    - Stall held high.
    - On i_jump: pc = {i_jump_pc[31:2],2'b00}, o_is_jump cleared with the next load, state→FETCH.
    - i_jump is accepted even if o_valid is still set.
    - i_jump in FETCH state is ignored.
- Simultaneous events:
  - Decode accepts and cache returns in the same cycle: new word loads; o_valid stays 1.
  - i_jump in the same cycle decode accepts the jump instruction: both take effect.
- First fetch issue is no earlier than the cycle after reset release. Latency from cache ready to o_valid is 1 cycle, registered.
- Throughput is one instruction per cache-ready pulse while decode keeps i_ready high.

Decomposition:
- Put in the shared CPU defines package: opcode localparams (OP_JAL, OP_JALR, OP_BRANCH, OP_SYSTEM) and fetch state typedef (FETCH, WAIT_JUMP).
- One natural sub-module: cpu_fetch_predecode, purely combinational, 32-bit word → is_jump. It is reused later by the branch predictor.

Test Plan:
1. Reset release with RESET_VECTOR=32'h0000_1000; cache returns 3 ADDI words on consecutive ready pulses, i_ready=1.
   → o_pc 1000, 1004, 1008 each with o_valid; o_fetch_count=3; o_icache_stall low throughout.
2. Decode holds i_ready=0 with o_valid=1.
   → o_icache_stall=1; o_icache_pc stays 1004; raising i_ready clears stall the same cycle.
3. Fetch JAL 32'h0080006F at 1008.
   → o_is_jump=1, stall high, pc stays 1008. i_jump with i_jump_pc=32'h0000_2003 → pc=2000, next fetched o_pc=2000.
4. pc=32'hFFFF_FFFC, non-jump word returned.
   → pc wraps to 0; o_pc=FFFF_FFFC.
5. Assert i_reset low while in WAIT_JUMP with o_valid=1.
   → all outputs 0 immediately (async), pc=RESET_VECTOR after release, no stale jump resolution.
6. i_jump pulsed in FETCH state.
   → ignored; PC sequence unchanged.
